// File: rtl/lpc_tpm_periph.sv
// rtl/lpc_tpm_periph.sv - LPC TPM I/O cycle front-end: field decode, SYNC/TAR generation, byte handshake
module lpc_tpm_periph #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lframe_i,
  inout  wire  [3:0]  lad_io,
  output logic [15:0] addr_o,
  inout  wire  [7:0]  data_io,
  output logic        data_wr,
  input  logic        wr_done,
  output logic        data_req,
  input  logic        data_rd
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START   = 4'd1;
  localparam logic [3:0] CYCTYPE = 4'd2;
  localparam logic [3:0] ADDR    = 4'd3;
  localparam logic [3:0] WDATA   = 4'd4;
  localparam logic [3:0] HTAR    = 4'd5;
  localparam logic [3:0] SYNC    = 4'd6;
  localparam logic [3:0] RDATA   = 4'd7;
  localparam logic [3:0] PTAR    = 4'd8;
  localparam logic [7:0] MAX_W   = 8'(MAX_WAIT);

  logic [3:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  start_q, start_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  lad_q, lad_d;
  logic        lad_en_q, lad_en_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic        pend_q, pend_d;
  logic        issue, do_sync, ready, busy;

  // A stale data_rd/wr_done from an earlier cycle must not complete the new one.
  assign ready = is_wr_q ? (wr_q & wr_done) : (req_q & data_rd);
  assign busy  = data_rd | wr_done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    lad_d    = lad_q;
    lad_en_d = 1'b0;
    req_d    = req_q;
    wr_d     = wr_q;
    pend_d   = pend_q;
    issue    = 1'b0;
    do_sync  = 1'b0;
    if (!lframe_i) begin
      state_d = START;
      start_d = lad_io;
      cnt_d   = 2'd0;
      req_d   = 1'b0;
      wr_d    = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        START: begin
          if (start_q == 4'b0101 && lad_io[3:2] == 2'b00) begin
            state_d = CYCTYPE;
            is_wr_d = lad_io[1];
          end else begin
            state_d = IDLE;
          end
        end
        CYCTYPE: begin
          addr_d  = {addr_q[11:0], lad_io};
          cnt_d   = 2'd1;
          wait_d  = 8'd0;
          state_d = ADDR;
        end
        ADDR: begin
          addr_d = {addr_q[11:0], lad_io};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = WDATA;
            end else begin
              state_d = HTAR;
              issue   = 1'b1;
            end
          end
        end
        WDATA: begin
          if (cnt_q == 2'd0) begin
            wdata_d[3:0] = lad_io;
            cnt_d        = 2'd1;
          end else begin
            wdata_d[7:4] = lad_io;
            cnt_d        = 2'd0;
            state_d      = HTAR;
            issue        = 1'b1;
          end
        end
        HTAR: begin
          issue = pend_q & ~busy;
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = 2'd0;
            do_sync = 1'b1;
          end
        end
        SYNC: begin
          issue   = pend_q & ~busy;
          do_sync = 1'b1;
        end
        RDATA: begin
          lad_en_d = 1'b1;
          if (cnt_q == 2'd0) begin
            lad_d = rdata_q[3:0];
            cnt_d = 2'd1;
          end else begin
            lad_d   = rdata_q[7:4];
            cnt_d   = 2'd0;
            state_d = PTAR;
          end
        end
        PTAR: begin
          if (cnt_q == 2'd0) begin
            lad_en_d = 1'b1;
            lad_d    = 4'b1111;
            cnt_d    = 2'd1;
          end else begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (issue) begin
        if (busy) begin
          pend_d = 1'b1;
        end else begin
          pend_d = 1'b0;
          if (is_wr_q) wr_d = 1'b1;
          else         req_d = 1'b1;
        end
      end

      // SYNC nibble for the following clock; ready takes priority over the wait limit.
      if (do_sync) begin
        lad_en_d = 1'b1;
        state_d  = SYNC;
        if (ready) begin
          lad_d = 4'b0000;
          if (is_wr_q) begin
            wr_d    = 1'b0;
            state_d = PTAR;
          end else begin
            rdata_d = data_io;
            req_d   = 1'b0;
            state_d = RDATA;
          end
        end else if (wait_q == MAX_W) begin
          lad_d   = 4'b1010;
          req_d   = 1'b0;
          wr_d    = 1'b0;
          pend_d  = 1'b0;
          state_d = PTAR;
        end else begin
          lad_d  = 4'b0110;
          wait_d = wait_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      start_q  <= 4'd0;
      is_wr_q  <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      wait_q   <= 8'd0;
      lad_q    <= 4'd0;
      lad_en_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      lad_q    <= lad_d;
      lad_en_q <= lad_en_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      pend_q   <= pend_d;
    end
  end

  assign lad_io   = lad_en_q ? lad_q : 4'bz;
  assign data_io  = (wr_q && !data_rd) ? wdata_q : 8'bz;
  assign addr_o   = addr_q;
  assign data_req = req_q;
  assign data_wr  = wr_q;

endmodule
